// File: rtl/spi_pkg.sv
// Shared SPI types: controller state, mode encodings and edge-polarity helpers.
package spi_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_state_e;

   localparam logic [1:0] SPI_MODE0 = 2'd0;
   localparam logic [1:0] SPI_MODE1 = 2'd1;
   localparam logic [1:0] SPI_MODE2 = 2'd2;
   localparam logic [1:0] SPI_MODE3 = 2'd3;

   function automatic logic [1:0] spi_mode(input logic cpol, input logic cpha);
      return {cpol, cpha};
   endfunction

   // The leading sclk edge is the rising one when the clock idles low.
   function automatic logic lead_is_rise(input logic cpol);
      return ~cpol;
   endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchroniser for one asynchronous pin, with rise/fall strobes
// derived from a third history flop.
module spi_sync #(
   parameter logic IDLE_LVL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic pin_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [2:0] sync_q;

   // Shift the pin through the synchroniser and history stages.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= {3{IDLE_LVL}};
      end else begin
         sync_q <= {sync_q[1:0], pin_i};
      end
   end

   assign level_o = sync_q[1];
   assign rise_o  = sync_q[1] & ~sync_q[2];
   assign fall_o  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_slave_core.sv
// Oversampling SPI slave, all four modes, DATA_W-bit words, valid/ready word ports.
// Optional sticky status flags when SPI_SLAVE_STATUS_EN is defined.
module spi_slave_core
   import spi_pkg::*;
#(
   parameter int unsigned        DATA_W  = 8,
   parameter logic               CPOL    = 1'b0,
   parameter logic               CPHA    = 1'b0,
   parameter logic [DATA_W-1:0]  TX_FILL = {DATA_W{1'b0}}
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              busy
`ifdef SPI_SLAVE_STATUS_EN
   ,
   output logic              rx_overrun,
   output logic              tx_underflow
`endif
);

   localparam int unsigned      CNT_W     = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
   localparam logic [1:0]       MODE      = spi_mode(CPOL, CPHA);
   localparam logic             LEAD_RISE = lead_is_rise(CPOL);
   localparam logic             SAMPLE_ON_LEAD = (MODE == SPI_MODE0) || (MODE == SPI_MODE2);

   logic cs_lvl_s, cs_fall_s, cs_rise_unused;
   logic sclk_rise_s, sclk_fall_s, sclk_lvl_unused;
   logic mosi_lvl_s, mosi_rise_unused, mosi_fall_unused;

   spi_sync #(.IDLE_LVL(CPOL)) u_sync_sclk (
      .clk(clk), .reset(reset), .pin_i(sclk),
      .level_o(sclk_lvl_unused), .rise_o(sclk_rise_s), .fall_o(sclk_fall_s)
   );

   spi_sync #(.IDLE_LVL(1'b1)) u_sync_cs (
      .clk(clk), .reset(reset), .pin_i(cs_n),
      .level_o(cs_lvl_s), .rise_o(cs_rise_unused), .fall_o(cs_fall_s)
   );

   spi_sync #(.IDLE_LVL(1'b0)) u_sync_mosi (
      .clk(clk), .reset(reset), .pin_i(mosi),
      .level_o(mosi_lvl_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
   );

   spi_state_e        state_q;
   logic [DATA_W-1:0] shreg_q;
   logic [DATA_W-1:0] rx_sh_q;
   logic [DATA_W-1:0] rx_data_q;
   logic [CNT_W-1:0]  bit_cnt_q;
   logic              hold_q;
   logic              miso_oe_q;
   logic              rx_valid_q;

   logic              lead_s, trail_s, sample_s, shift_s;
   logic              entry_s, done_s, load_s, rx_accept_s;
   logic [DATA_W-1:0] load_word_s;
   logic [DATA_W-1:0] rx_word_s;

   assign lead_s      = LEAD_RISE ? sclk_rise_s : sclk_fall_s;
   assign trail_s     = LEAD_RISE ? sclk_fall_s : sclk_rise_s;
   assign sample_s    = SAMPLE_ON_LEAD ? lead_s : trail_s;
   assign shift_s     = SAMPLE_ON_LEAD ? trail_s : lead_s;

   assign entry_s     = (state_q == IDLE) & cs_fall_s;
   assign done_s      = (state_q == ACTIVE) & ~cs_lvl_s & sample_s & (bit_cnt_q == LAST_BIT);
   assign load_s      = entry_s | done_s;
   assign load_word_s = tx_valid ? tx_data : TX_FILL;
   assign rx_word_s   = {rx_sh_q[DATA_W-2:0], mosi_lvl_s};
   assign rx_accept_s = done_s & (~rx_valid_q | rx_ready);

   // hold_q suppresses the first shift after a load so the freshly loaded MSB
   // is not shifted away: on the trailing edge closing a CPHA=0 word, or on
   // the first leading edge of every CPHA=1 word.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         shreg_q    <= {DATA_W{1'b0}};
         rx_sh_q    <= {DATA_W{1'b0}};
         rx_data_q  <= {DATA_W{1'b0}};
         bit_cnt_q  <= {CNT_W{1'b0}};
         hold_q     <= 1'b0;
         miso_oe_q  <= 1'b0;
         rx_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cs_fall_s) begin
                  state_q   <= ACTIVE;
                  shreg_q   <= load_word_s;
                  bit_cnt_q <= {CNT_W{1'b0}};
                  hold_q    <= CPHA;
                  miso_oe_q <= 1'b1;
               end
            end
            ACTIVE: begin
               if (cs_lvl_s) begin
                  state_q   <= IDLE;
                  bit_cnt_q <= {CNT_W{1'b0}};
                  hold_q    <= 1'b0;
                  miso_oe_q <= 1'b0;
               end else if (sample_s) begin
                  if (bit_cnt_q == LAST_BIT) begin
                     bit_cnt_q <= {CNT_W{1'b0}};
                     shreg_q   <= load_word_s;
                     hold_q    <= 1'b1;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                     rx_sh_q   <= rx_word_s;
                  end
               end else if (shift_s) begin
                  if (hold_q) begin
                     hold_q <= 1'b0;
                  end else begin
                     shreg_q <= {shreg_q[DATA_W-2:0], 1'b0};
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase

         if (rx_accept_s) begin
            rx_data_q  <= rx_word_s;
            rx_valid_q <= 1'b1;
         end else if (rx_ready) begin
            rx_valid_q <= 1'b0;
         end
      end
   end

`ifdef SPI_SLAVE_STATUS_EN
   logic overrun_q, underflow_q;

   // Sticky status: only reset clears them.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overrun_q   <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (done_s & rx_valid_q & ~rx_ready) begin
            overrun_q <= 1'b1;
         end
         if (load_s & ~tx_valid) begin
            underflow_q <= 1'b1;
         end
      end
   end

   assign rx_overrun   = overrun_q;
   assign tx_underflow = underflow_q;
`endif

   assign miso     = shreg_q[DATA_W-1];
   assign miso_oe  = miso_oe_q;
   assign tx_ready = load_s;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign busy     = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed + randomised bench: three slaves (mode 0/8-bit, mode 3/16-bit, mode 1/8-bit)
// driven by a behavioural SPI master and checked against a word-level model.
module tb_spi_slave_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [2:0]  sclk_v, cs_v, mosi_v, txv_v, rxr_v;
   logic [2:0]  miso_v, oe_v, txr_v, rxv_v, busy_v;
   logic [7:0]  txd_a, rxd_a, txd_c, rxd_c;
   logic [15:0] txd_b, rxd_b;
`ifdef SPI_SLAVE_STATUS_EN
   logic [2:0]  ovr_v, unf_v;
`endif

   int vectors = 0;
   int miscompares = 0;

   int          ld_cnt [3] = '{0, 0, 0};
   logic [15:0] rxq_b [$];

   logic [31:0] m_rx_data  [3];
   logic        m_rx_valid [3];
   logic        m_ovr      [3];

   spi_slave_core #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0)) u_a (
      .clk(clk), .reset(reset), .sclk(sclk_v[0]), .cs_n(cs_v[0]), .mosi(mosi_v[0]),
      .miso(miso_v[0]), .miso_oe(oe_v[0]), .tx_data(txd_a), .tx_valid(txv_v[0]),
      .tx_ready(txr_v[0]), .rx_data(rxd_a), .rx_valid(rxv_v[0]), .rx_ready(rxr_v[0]),
      .busy(busy_v[0])
`ifdef SPI_SLAVE_STATUS_EN
      , .rx_overrun(ovr_v[0]), .tx_underflow(unf_v[0])
`endif
   );

   spi_slave_core #(.DATA_W(16), .CPOL(1'b1), .CPHA(1'b1)) u_b (
      .clk(clk), .reset(reset), .sclk(sclk_v[1]), .cs_n(cs_v[1]), .mosi(mosi_v[1]),
      .miso(miso_v[1]), .miso_oe(oe_v[1]), .tx_data(txd_b), .tx_valid(txv_v[1]),
      .tx_ready(txr_v[1]), .rx_data(rxd_b), .rx_valid(rxv_v[1]), .rx_ready(rxr_v[1]),
      .busy(busy_v[1])
`ifdef SPI_SLAVE_STATUS_EN
      , .rx_overrun(ovr_v[1]), .tx_underflow(unf_v[1])
`endif
   );

   spi_slave_core #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b1)) u_c (
      .clk(clk), .reset(reset), .sclk(sclk_v[2]), .cs_n(cs_v[2]), .mosi(mosi_v[2]),
      .miso(miso_v[2]), .miso_oe(oe_v[2]), .tx_data(txd_c), .tx_valid(txv_v[2]),
      .tx_ready(txr_v[2]), .rx_data(rxd_c), .rx_valid(rxv_v[2]), .rx_ready(rxr_v[2]),
      .busy(busy_v[2])
`ifdef SPI_SLAVE_STATUS_EN
      , .rx_overrun(ovr_v[2]), .tx_underflow(unf_v[2])
`endif
   );

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (txr_v[k]) ld_cnt[k] <= ld_cnt[k] + 1;
      end
      if (rxv_v[1] && rxr_v[1]) rxq_b.push_back(rxd_b);
   end

   initial begin
      #500us;
      $display("FAIL watchdog: observed no finish, expected finish before 500us");
      $fatal(1, "watchdog expired");
   end

   function automatic logic cpol_of(input int d);
      return (d == 1);
   endfunction

   function automatic logic cpha_of(input int d);
      return (d != 0);
   endfunction

   function automatic int width_of(input int d);
      return (d == 1) ? 16 : 8;
   endfunction

   function automatic logic [31:0] mask_of(input int d);
      return (d == 1) ? 32'h0000_FFFF : 32'h0000_00FF;
   endfunction

   function automatic logic [31:0] get_rx(input int d);
      case (d)
         0:       return {24'h0, rxd_a};
         1:       return {16'h0, rxd_b};
         default: return {24'h0, rxd_c};
      endcase
   endfunction

   function automatic logic [31:0] qget(input int i);
      return (rxq_b.size() > i) ? {16'h0, rxq_b[i]} : 32'hDEAD_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_tx(input int d, input logic [31:0] v, input logic valid);
      case (d)
         0:       txd_a = v[7:0];
         1:       txd_b = v[15:0];
         default: txd_c = v[7:0];
      endcase
      txv_v[d] = valid;
   endtask

   task automatic select(input int d);
      cs_v[d] = 1'b0;
      ticks(8);
   endtask

   task automatic deselect(input int d);
      ticks(8);
      cs_v[d] = 1'b1;
      ticks(8);
   endtask

   // Behavioural master: MSB first, half sclk period = 8 clk.
   task automatic shift_bits(input int d, input int nb, input logic [31:0] mo,
                             output logic [31:0] mi);
      int   w    = width_of(d);
      logic cpol = cpol_of(d);
      logic cpha = cpha_of(d);
      mi = 32'h0;
      for (int k = 0; k < nb; k++) begin
         int i = w - 1 - k;
         if (!cpha) begin
            mosi_v[d] = mo[i];
            ticks(8);
            mi[i] = miso_v[d];
            sclk_v[d] = ~cpol;
            ticks(8);
            sclk_v[d] = cpol;
         end else begin
            sclk_v[d] = ~cpol;
            mosi_v[d] = mo[i];
            ticks(8);
            mi[i] = miso_v[d];
            sclk_v[d] = cpol;
            ticks(8);
         end
      end
   endtask

   task automatic model_word(input int d, input logic [31:0] word);
      if (!m_rx_valid[d]) begin
         m_rx_data[d]  = word;
         m_rx_valid[d] = 1'b1;
      end else begin
         m_ovr[d] = 1'b1;
      end
   endtask

   task automatic consume(input int d, input string tag);
      chk({tag, "_rx_valid"}, {31'h0, rxv_v[d]}, {31'h0, m_rx_valid[d]});
      chk({tag, "_rx_data"}, get_rx(d), m_rx_data[d]);
      rxr_v[d] = 1'b1;
      ticks(1);
      rxr_v[d] = 1'b0;
      m_rx_valid[d] = 1'b0;
      ticks(1);
      chk({tag, "_rx_valid_clr"}, {31'h0, rxv_v[d]}, 32'h0);
   endtask

   task automatic one_word(input int d, input logic [31:0] tx, input logic txv,
                           input logic [31:0] mo, input string tag);
      logic [31:0] mi;
      int          pre;
      set_tx(d, tx, txv);
      pre = ld_cnt[d];
      select(d);
      chk({tag, "_tx_ready_pulse"}, ld_cnt[d] - pre, 32'd1);
      shift_bits(d, width_of(d), mo, mi);
      deselect(d);
      chk({tag, "_master_rx"}, mi, txv ? (tx & mask_of(d)) : 32'h0);
      model_word(d, mo & mask_of(d));
      consume(d, tag);
   endtask

   logic [31:0] mi0, mi1, w0, w1;

   initial begin
      for (int k = 0; k < 3; k++) begin
         m_rx_data[k] = 32'h0; m_rx_valid[k] = 1'b0; m_ovr[k] = 1'b0;
      end
      reset = 1'b0;
      sclk_v = 3'b010; cs_v = 3'b111; mosi_v = 3'b000; txv_v = 3'b000; rxr_v = 3'b000;
      txd_a = 8'h0; txd_b = 16'h0; txd_c = 8'h0;
      ticks(3);
      chk("rst_miso",     {31'h0, miso_v[0]}, 32'h0);
      chk("rst_miso_oe",  {29'h0, oe_v},      32'h0);
      chk("rst_tx_ready", {29'h0, txr_v},     32'h0);
      chk("rst_rx_valid", {29'h0, rxv_v},     32'h0);
      chk("rst_rx_data",  get_rx(0) | get_rx(1) | get_rx(2), 32'h0);
      chk("rst_busy",     {29'h0, busy_v},    32'h0);
`ifdef SPI_SLAVE_STATUS_EN
      chk("rst_flags",    {26'h0, ovr_v, unf_v}, 32'h0);
`endif
      reset = 1'b1;
      ticks(5);

      // Mode 0: TX 0xA5, master sends 0x3C; rx_valid held until rx_ready.
      set_tx(0, 32'hA5, 1'b1);
      select(0);
      chk("m0_busy", {31'h0, busy_v[0]}, 32'h1);
      chk("m0_miso_oe", {31'h0, oe_v[0]}, 32'h1);
      shift_bits(0, 8, 32'h3C, mi0);
      deselect(0);
      chk("m0_master_rx", mi0, 32'hA5);
      model_word(0, 32'h3C);
      ticks(20);
      consume(0, "m0");

      // Mode 3, 16-bit two-word burst with rx_ready held high.
      rxq_b.delete();
      rxr_v[1] = 1'b1;
      set_tx(1, 32'h1234, 1'b1);
      select(1);
      set_tx(1, 32'hBEEF, 1'b1);
      shift_bits(1, 16, 32'hCAFE, mi0);
      set_tx(1, 32'h0, 1'b0);
      shift_bits(1, 16, 32'h0F0F, mi1);
      deselect(1);
      rxr_v[1] = 1'b0;
      chk("m3_master_w0", mi0, 32'h1234);
      chk("m3_master_w1", mi1, 32'hBEEF);
      chk("m3_rx_count", rxq_b.size(), 32'd2);
      chk("m3_rx_w0", qget(0), 32'hCAFE);
      chk("m3_rx_w1", qget(1), 32'h0F0F);
      chk("m3_rx_valid_clr", {31'h0, rxv_v[1]}, 32'h0);

      // TX underflow: fill word goes out.
      one_word(0, $urandom, 1'b0, $urandom, "underflow");
`ifdef SPI_SLAVE_STATUS_EN
      chk("underflow_flag", {31'h0, unf_v[0]}, 32'h1);
      chk("overrun_flag_clear", {31'h0, ovr_v[0]}, 32'h0);
`endif

      // Overrun: two words with rx_ready low, second is dropped.
      w0 = $urandom & 32'hFF; w1 = $urandom & 32'hFF;
      mi0 = $urandom & 32'hFF;
      set_tx(0, mi0, 1'b1);
      select(0);
      set_tx(0, mi0 ^ 32'hFF, 1'b1);
      shift_bits(0, 8, w0, mi1);
      chk("ovr_master_w0", mi1, mi0);
      shift_bits(0, 8, w1, mi1);
      deselect(0);
      chk("ovr_master_w1", mi1, mi0 ^ 32'hFF);
      model_word(0, w0);
      model_word(0, w1);
`ifdef SPI_SLAVE_STATUS_EN
      chk("overrun_flag", {31'h0, ovr_v[0]}, {31'h0, m_ovr[0]});
`endif
      consume(0, "ovr");

      // Mode 1 abort after 5 bits, then a clean word.
      set_tx(2, $urandom, 1'b1);
      select(2);
      shift_bits(2, 5, $urandom, mi0);
      cs_v[2] = 1'b1;
      ticks(3);
      chk("abort_busy", {31'h0, busy_v[2]}, 32'h0);
      chk("abort_miso_oe", {31'h0, oe_v[2]}, 32'h0);
      ticks(20);
      chk("abort_no_rx", {31'h0, rxv_v[2]}, 32'h0);
      one_word(2, $urandom, 1'b1, $urandom, "post_abort");

      // Reset mid-word, then a clean word.
      set_tx(0, $urandom, 1'b1);
      select(0);
      shift_bits(0, 3, $urandom, mi0);
      reset = 1'b0;
      ticks(1);
      chk("midrst_outputs", {26'h0, miso_v[0], oe_v[0], txr_v[0], rxv_v[0], busy_v[0], 1'b0}, 32'h0);
      chk("midrst_rx_data", get_rx(0), 32'h0);
`ifdef SPI_SLAVE_STATUS_EN
      chk("midrst_flags", {30'h0, ovr_v[0], unf_v[0]}, 32'h0);
`endif
      cs_v[0] = 1'b1;
      sclk_v[0] = 1'b0;
      ticks(2);
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         m_rx_data[k] = 32'h0; m_rx_valid[k] = 1'b0; m_ovr[k] = 1'b0;
      end
      ticks(5);
      one_word(0, $urandom, 1'b1, $urandom, "post_reset");

      // Randomised words on every slave.
      for (int r = 0; r < 3; r++) begin
         for (int d = 0; d < 3; d++) begin
            one_word(d, $urandom, 1'($urandom_range(0, 1)), $urandom, $sformatf("rand%0d_%0d", r, d));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
